btn_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the toggle-state FSM.
- Takes a raw, asynchronous, bouncing push-button level and synchronises it to clk, then debounces it with a counter-qualified state machine.
- Emits one single-cycle press pulse per debounced press. That pulse drives the toggle FSM's `in` input.
- Also provides the debounced level, a release pulse, and a wrapping press counter for LED/debug visibility.

---
 rtl/btn_debounce_pulse.sv | 122 ++++++++++++
 tb/tb_btn_debounce_pulse.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Synchronises and debounces a raw push-button, emitting registered press/release pulses, level and press count.
// Latency: raw edge stable before edge k -> pulse at edge k+DEBOUNCE_CYCLES+1; no backpressure (free-running).
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [7:0]       r_press_cnt;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_level_nxt;

    // btn_raw is asynchronous: only r_sync2 may feed the FSM.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_CHK;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = REL_CHK;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            REL_CHK: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Level follows the next state so it moves in the same cycle as the pulses.
    assign w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == REL_CHK);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            if (w_press_nxt) begin
                r_press_cnt <= r_press_cnt + 8'd1;
            end
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_cnt     = r_press_cnt;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: two instances (window 4 and 16) share one raw input
// and are compared every cycle against a run-length reference model plus scenario constants.
module tb_btn_debounce_pulse;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       btn_raw;
    logic       lvl4, pp4, rp4, lvl16, pp16, rp16;
    logic [7:0] pc4, pc16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk(clk), .areset_n(areset_n), .btn_raw(btn_raw),
        .btn_level(lvl4), .press_pulse(pp4), .release_pulse(rp4), .press_cnt(pc4)
    );

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(16)) u_dut16 (
        .clk(clk), .areset_n(areset_n), .btn_raw(btn_raw),
        .btn_level(lvl16), .press_pulse(pp16), .release_pulse(rp16), .press_cnt(pc16)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
    logic       m_p1, m_p2;
    logic       m_lvl [2];
    logic       m_pp  [2];
    logic       m_rp  [2];
    logic [7:0] m_cnt [2];
    int         m_run [2];

    function automatic int dwin(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic logic [10:0] obs_vec(input int d);
        return (d == 0) ? {lvl4, pp4, rp4, pc4} : {lvl16, pp16, rp16, pc16};
    endfunction

    function automatic logic [10:0] exp_vec(input int d);
        return {m_lvl[d], m_pp[d], m_rp[d], m_cnt[d]};
    endfunction

    task automatic model_reset();
        m_p1 = 1'b0;
        m_p2 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_lvl[d] = 1'b0; m_pp[d] = 1'b0; m_rp[d] = 1'b0;
            m_cnt[d] = 8'd0; m_run[d] = 0;
        end
    endtask

    task automatic model_step(input logic raw);
        logic s;
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = raw;
        for (int d = 0; d < 2; d++) begin
            m_pp[d] = 1'b0;
            m_rp[d] = 1'b0;
            if (s != m_lvl[d]) begin
                m_run[d] = m_run[d] + 1;
                if (m_run[d] == dwin(d)) begin
                    m_lvl[d] = s;
                    m_run[d] = 0;
                    if (s) begin
                        m_pp[d]  = 1'b1;
                        m_cnt[d] = m_cnt[d] + 8'd1;
                    end else begin
                        m_rp[d] = 1'b1;
                    end
                end
            end else begin
                m_run[d] = 0;
            end
        end
    endtask

    // Drive at the falling edge, model at the rising edge, leave the caller at the next falling edge.
    task automatic tick(input logic raw);
        btn_raw = raw;
        @(posedge clk);
        model_step(raw);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        btn_raw  = 1'b0;
        model_reset();
        #12;
        total++;
        if ({obs_vec(0), obs_vec(1)} !== 22'd0) begin
            bad++;
            $display("FAIL reset_state got=%h/%h want=0/0", obs_vec(0), obs_vec(1));
        end
        @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL reset_idle dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        logic toggle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            toggle ^= pp4;
            pulses += int'(pp4);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL clean_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if ({lvl4, pp4} !== {(i >= 5), (i == 5)}) begin
                bad++;
                $display("FAIL clean_edge edge=%0d lvl/pulse got=%b%b want=%b%b", i, lvl4, pp4, (i >= 5), (i == 5));
            end
        end
        total++;
        if (pc4 !== 8'd1 || pulses != 1 || toggle !== 1'b1) begin
            bad++;
            $display("FAIL clean_count cnt=%0d pulses=%0d toggle=%b want 1/1/1", pc4, pulses, toggle);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL clean_rel dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_press_bounce();
        logic       pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] start = pc4;
        int pulses = 0;
        for (int i = 0; i < 18; i++) begin
            tick((i < 6) ? pat[i] : 1'b1);
            pulses += int'(pp4);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL bounce_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if (pp4 !== (i == 11)) begin
                bad++;
                $display("FAIL bounce_pulse tick=%0d got=%b want=%b", i, pp4, (i == 11));
            end
        end
        total++;
        if (pulses != 1 || pc4 !== start + 8'd1) begin
            bad++;
            $display("FAIL bounce_count pulses=%0d cnt=%0d want 1/%0d", pulses, pc4, start + 8'd1);
        end
    endtask

    task automatic test_release_glitch();
        int rels = 0;
        for (int i = 0; i < 12; i++) begin
            tick((i < 2) ? 1'b0 : 1'b1);
            rels += int'(rp4);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL glitch_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if ({lvl4, rp4} !== 2'b10) begin
                bad++;
                $display("FAIL glitch_hold tick=%0d lvl/rel got=%b%b want=10", i, lvl4, rp4);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            rels += int'(rp4);
            total++;
            if ({lvl4, rp4} !== {(i < 5), (i == 5)}) begin
                bad++;
                $display("FAIL glitch_release tick=%0d lvl/rel got=%b%b want=%b%b", i, lvl4, rp4, (i < 5), (i == 5));
            end
        end
        total++;
        if (rels != 1) begin
            bad++;
            $display("FAIL glitch_rel_count got=%0d want=1", rels);
        end
    endtask

    task automatic test_long_hold();
        logic [7:0] start16 = pc16;
        int p4 = 0;
        int p16 = 0;
        for (int i = 0; i < 1040; i++) begin
            tick((i < 1000) ? 1'b1 : 1'b0);
            if (i < 1000) begin
                p4  += int'(pp4);
                p16 += int'(pp16);
            end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL hold_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
        end
        total++;
        if (p4 != 1 || p16 != 1 || pc16 !== start16 + 8'd1) begin
            bad++;
            $display("FAIL hold_once p4=%0d p16=%0d cnt16=%0d want 1/1/%0d", p4, p16, pc16, start16 + 8'd1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(1'b1);
        areset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({obs_vec(0), obs_vec(1)} !== 22'd0) begin
            bad++;
            $display("FAIL midreset_clear got=%h/%h want=0/0", obs_vec(0), obs_vec(1));
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({obs_vec(0), obs_vec(1)} !== 22'd0) begin
            bad++;
            $display("FAIL midreset_held got=%h/%h want=0/0", obs_vec(0), obs_vec(1));
        end
        areset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1);
            total++;
            if (pp4 !== (i == 5) || obs_vec(0) !== exp_vec(0)) begin
                bad++;
                $display("FAIL midreset_pulse tick=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
        end
        total++;
        if (pc4 !== 8'd1) begin
            bad++;
            $display("FAIL midreset_count got=%0d want=1", pc4);
        end
        for (int i = 0; i < 10; i++) tick(1'b0);
    endtask

    task automatic test_wrap();
        int rels = 0;
        int presses = 0;
        areset_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        areset_n = 1'b1;
        total++;
        if (pc4 !== 8'd0) begin
            bad++;
            $display("FAIL wrap_start got=%0d want=0", pc4);
        end
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 12; i++) begin
                tick((i < 6) ? 1'b1 : 1'b0);
                rels += int'(rp4);
                if (pp4 === 1'b1) begin
                    presses++;
                    total++;
                    if (pc4 !== 8'(presses)) begin
                        bad++;
                        $display("FAIL wrap_step press=%0d got=%0d want=%0d", presses, pc4, 8'(presses));
                    end
                end
                if ($urandom_range(0, 15) == 0) begin
                    for (int d = 0; d < 2; d++) begin
                        total++;
                        if (obs_vec(d) !== exp_vec(d)) begin
                            bad++;
                            $display("FAIL wrap_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                        end
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b0);
        total++;
        if (pc4 !== 8'd0 || rels != 256 || presses != 256) begin
            bad++;
            $display("FAIL wrap_end cnt=%0d rels=%0d presses=%0d want 0/256/256", pc4, rels, presses);
        end
    endtask

    task automatic test_random();
        logic lvl_raw = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) lvl_raw = ~lvl_raw;
            tick(($urandom_range(0, 7) == 0) ? ~lvl_raw : lvl_raw);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL random_model dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if ((pp4 & rp4) !== 1'b0 || (pp16 & rp16) !== 1'b0) begin
                bad++;
                $display("FAIL random_excl cyc=%0d pp/rp4=%b%b pp/rp16=%b%b want no overlap", cyc, pp4, rp4, pp16, rp16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_glitch();
        test_long_hold();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
